// File: rtl/axis_frame_arbiter_pkg.sv
// rtl/axis_frame_arbiter_pkg.sv - shared types and constants for the frame arbiter
package axis_frame_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int SOF_BIT   = 0;
    localparam int SID_WIDTH = 1;

    typedef logic [SID_WIDTH-1:0] sid_t;

endpackage

// File: rtl/axis_rr_picker.sv
// rtl/axis_rr_picker.sv - combinational two-way round-robin picker
module axis_rr_picker
    import axis_frame_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  sid_t       last_ptr,
    output logic       grant_valid,
    output sid_t       grant_id
);

    // A lone requester wins; with two, the one not served last wins.
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = ~last_ptr;
        end else begin
            grant_id = sid_t'(req[1]);
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular two-source AXIS arbiter (optional watchdog: AXIS_FRAME_ARBITER_TIMEOUT_EN)
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH      = 8,
    parameter int AXIS_DATA_USER_WIDTH = 1,
    parameter int LINE_COUNT_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES       = 1000000
) (
    input  logic                            i_axi_clk,
    input  logic                            i_axi_rst,
    input  logic                            i_enable,
    input  logic [LINE_COUNT_WIDTH-1:0]     i_lines_per_frame,
    input  logic                            i_clear,
    input  logic [AXIS_DATA_USER_WIDTH-1:0] i_s0_tuser,
    input  logic                            i_s0_tvalid,
    input  logic                            i_s0_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0]      i_s0_tdata,
    output logic                            o_s0_tready,
    input  logic [AXIS_DATA_USER_WIDTH-1:0] i_s1_tuser,
    input  logic                            i_s1_tvalid,
    input  logic                            i_s1_tlast,
    input  logic [AXIS_DATA_WIDTH-1:0]      i_s1_tdata,
    output logic                            o_s1_tready,
    output logic [AXIS_DATA_USER_WIDTH-1:0] o_m_tuser,
    output logic                            o_m_tvalid,
    output logic                            o_m_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]      o_m_tdata,
    input  logic                            i_m_tready,
    output logic                            o_busy,
    output logic                            o_grant_id,
    output logic                            o_short_frame_stb,
    output logic                            o_timeout
);

    state_t                              state;
    sid_t                                grant_id;
    sid_t                                last_ptr;
    logic                                first_beat;
    logic [LINE_COUNT_WIDTH-1:0]         line_cnt;
    logic [LINE_COUNT_WIDTH-1:0]         cnt_inc;
    logic                                short_stb;

    logic                                s0_req;
    logic                                s1_req;
    logic                                pick_valid;
    sid_t                                pick_id;

    logic [AXIS_DATA_USER_WIDTH-1:0]     g_user;
    logic                                g_valid;
    logic                                g_last;
    logic [AXIS_DATA_WIDTH-1:0]          g_data;
    logic                                g_abort;
    logic                                g_hs;
    logic                                frame_done;

    assign s0_req = i_s0_tvalid & i_s0_tuser[SOF_BIT];
    assign s1_req = i_s1_tvalid & i_s1_tuser[SOF_BIT];

    axis_rr_picker u_picker (
        .req         ({s1_req, s0_req}),
        .last_ptr    (last_ptr),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    // Select the granted source's stream fields.
    always_comb begin
        if (grant_id == sid_t'(1)) begin
            g_user  = i_s1_tuser;
            g_valid = i_s1_tvalid;
            g_last  = i_s1_tlast;
            g_data  = i_s1_tdata;
        end else begin
            g_user  = i_s0_tuser;
            g_valid = i_s0_tvalid;
            g_last  = i_s0_tlast;
            g_data  = i_s0_tdata;
        end
    end

    // A fresh SOF after the first beat cuts the frame short and is held back for re-arbitration.
    assign g_abort = (state == ST_GRANT) && g_valid && g_user[SOF_BIT] && !first_beat;
    assign g_hs    = (state == ST_GRANT) && g_valid && i_m_tready && !g_abort;
    assign cnt_inc = (&line_cnt) ? line_cnt : line_cnt + 1'b1;
    assign frame_done = g_hs && g_last && (i_lines_per_frame != '0) && (cnt_inc == i_lines_per_frame);

    // Handshake routing: drop pre-SOF beats in IDLE, pass the granted source straight through in GRANT.
    always_comb begin
        o_s0_tready = 1'b0;
        o_s1_tready = 1'b0;
        o_m_tvalid  = 1'b0;
        o_m_tuser   = g_user;
        o_m_tlast   = g_last;
        o_m_tdata   = g_data;
        if (i_axi_rst) begin
            if (state == ST_IDLE) begin
                o_s0_tready = i_s0_tvalid & ~i_s0_tuser[SOF_BIT];
                o_s1_tready = i_s1_tvalid & ~i_s1_tuser[SOF_BIT];
            end else if (!g_abort) begin
                o_m_tvalid = g_valid;
                if (grant_id == sid_t'(1)) begin
                    o_s1_tready = i_m_tready;
                end else begin
                    o_s0_tready = i_m_tready;
                end
            end
        end
    end

`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               timeout_q;
    logic               stall_hit;

    assign stall_hit = (state == ST_GRANT) && !g_hs && !g_abort && (stall_cnt == STALL_LAST);
    assign o_timeout = timeout_q;

    // Watchdog: count granted cycles without a handshake; sticky flag cleared by i_clear unless set again.
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (i_clear) begin
                timeout_q <= 1'b0;
            end
            if (state != ST_GRANT || g_hs || g_abort || stall_hit) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (stall_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    logic unused_clear;
    logic stall_hit;
    assign unused_clear = i_clear;
    assign stall_hit    = 1'b0;
    assign o_timeout    = 1'b0;
`endif

    // Frame FSM: arbitrate on SOF in IDLE, hold the grant until line count, early SOF or stall.
    always_ff @(posedge i_axi_clk) begin
        if (!i_axi_rst) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_ptr   <= sid_t'(1);
            first_beat <= 1'b0;
            line_cnt   <= '0;
            short_stb  <= 1'b0;
        end else begin
            short_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_enable && pick_valid) begin
                        state      <= ST_GRANT;
                        grant_id   <= pick_id;
                        first_beat <= 1'b1;
                        line_cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (g_abort) begin
                        state     <= ST_IDLE;
                        line_cnt  <= '0;
                        short_stb <= (i_lines_per_frame != '0);
                    end else if (frame_done) begin
                        state    <= ST_IDLE;
                        line_cnt <= '0;
                        last_ptr <= grant_id;
                    end else if (g_hs) begin
                        first_beat <= 1'b0;
                        if (g_last) begin
                            line_cnt <= cnt_inc;
                        end
                    end else if (stall_hit) begin
                        state    <= ST_IDLE;
                        line_cnt <= '0;
                        last_ptr <= grant_id;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy            = (state == ST_GRANT);
    assign o_grant_id        = grant_id;
    assign o_short_frame_stb = short_stb;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - directed self-checking bench for axis_frame_arbiter
module tb_axis_frame_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [15:0] lpf;
    logic        clr;
    logic [0:0]  s0_user, s1_user, m_user;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic [7:0]  s0_data, s1_data, m_data;
    logic        m_valid, m_last, m_ready;
    logic        busy, gid, short_stb, tmo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .AXIS_DATA_WIDTH      (8),
        .AXIS_DATA_USER_WIDTH (1),
        .LINE_COUNT_WIDTH     (16),
        .TIMEOUT_CYCLES       (16)
    ) dut (
        .i_axi_clk         (clk),
        .i_axi_rst         (rstn),
        .i_enable          (en),
        .i_lines_per_frame (lpf),
        .i_clear           (clr),
        .i_s0_tuser        (s0_user),
        .i_s0_tvalid       (s0_valid),
        .i_s0_tlast        (s0_last),
        .i_s0_tdata        (s0_data),
        .o_s0_tready       (s0_ready),
        .i_s1_tuser        (s1_user),
        .i_s1_tvalid       (s1_valid),
        .i_s1_tlast        (s1_last),
        .i_s1_tdata        (s1_data),
        .o_s1_tready       (s1_ready),
        .o_m_tuser         (m_user),
        .o_m_tvalid        (m_valid),
        .o_m_tlast         (m_last),
        .o_m_tdata         (m_data),
        .i_m_tready        (m_ready),
        .o_busy            (busy),
        .o_grant_id        (gid),
        .o_short_frame_stb (short_stb),
        .o_timeout         (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic src0(input logic v, input logic sof, input logic last, input logic [7:0] d);
        s0_valid = v; s0_user = sof; s0_last = last; s0_data = d;
    endtask

    task automatic src1(input logic v, input logic sof, input logic last, input logic [7:0] d);
        s1_valid = v; s1_user = sof; s1_last = last; s1_data = d;
    endtask

    // Advance to the next falling edge; inputs change here and outputs settle 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; lpf = 16'd3; clr = 1'b0; m_ready = 1'b1;
        src0(1'b1, 1'b0, 1'b0, 8'hA0);
        src1(1'b0, 1'b0, 1'b0, 8'h00);
        nxt(); nxt(); #1;
        chk("rst_s0_tready", s0_ready, 0);
        chk("rst_m_tvalid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", gid, 0);
        chk("rst_short", short_stb, 0);
        chk("rst_timeout", tmo, 0);

        // Mid-frame start: two non-SOF beats are dropped
        nxt(); rstn = 1'b1; src0(1'b1, 1'b0, 1'b0, 8'hA1); #1;
        chk("drop1_s0_tready", s0_ready, 1);
        chk("drop1_m_tvalid", m_valid, 0);
        nxt(); src0(1'b1, 1'b0, 1'b1, 8'hA2); #1;
        chk("drop2_s0_tready", s0_ready, 1);
        chk("drop2_m_tvalid", m_valid, 0);

        // Both SOF together: source 0 wins first
        nxt(); src0(1'b1, 1'b1, 1'b0, 8'h10); src1(1'b1, 1'b1, 1'b0, 8'h20); #1;
        chk("req_s0_tready", s0_ready, 0);
        chk("req_s1_tready", s1_ready, 0);
        chk("req_m_tvalid", m_valid, 0);
        chk("req_busy", busy, 0);
        nxt(); #1;
        chk("g0_busy", busy, 1);
        chk("g0_id", gid, 0);
        chk("g0_m_tvalid", m_valid, 1);
        chk("g0_m_tdata", m_data, 8'h10);
        chk("g0_m_tuser", m_user, 1);
        chk("g0_s0_tready", s0_ready, 1);
        chk("g0_s1_tready", s1_ready, 0);
        nxt(); src0(1'b1, 1'b0, 1'b1, 8'h11); #1;
        chk("f0_l1_data", m_data, 8'h11);
        chk("f0_l1_last", m_last, 1);
        nxt(); src0(1'b1, 1'b0, 1'b1, 8'h12); #1;
        chk("f0_l2_data", m_data, 8'h12);
        nxt(); src0(1'b1, 1'b0, 1'b1, 8'h13); #1;
        chk("f0_l3_data", m_data, 8'h13);
        chk("f0_l3_busy", busy, 1);

        // Frame over; both request again, source 1 wins round-robin
        nxt(); src0(1'b1, 1'b1, 1'b1, 8'h30); #1;
        chk("end0_busy", busy, 0);
        chk("end0_grant_id_hold", gid, 0);
        chk("end0_m_tvalid", m_valid, 0);
        chk("end0_s1_tready", s1_ready, 0);
        nxt(); #1;
        chk("g1_busy", busy, 1);
        chk("g1_id", gid, 1);
        chk("g1_m_tdata", m_data, 8'h20);
        chk("g1_s0_tready", s0_ready, 0);
        chk("g1_s1_tready", s1_ready, 1);

        // Output back-pressure for 50 cycles mid-frame
        nxt(); src1(1'b1, 1'b0, 1'b1, 8'h21); m_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            chk("stall_m_tvalid", m_valid, 1);
            chk("stall_m_tdata", m_data, 8'h21);
            chk("stall_s1_tready", s1_ready, 0);
            chk("stall_s0_tready", s0_ready, 0);
            nxt();
        end
        m_ready = 1'b1; #1;
        chk("unstall_s1_tready", s1_ready, 1);
        chk("unstall_m_tdata", m_data, 8'h21);
        nxt(); src1(1'b1, 1'b0, 1'b1, 8'h22); #1;
        chk("f1_l2_data", m_data, 8'h22);
        nxt(); src1(1'b1, 1'b0, 1'b1, 8'h23); #1;
        chk("f1_l3_data", m_data, 8'h23);
        chk("f1_l3_busy", busy, 1);

        // Short frame: lines_per_frame=4, new SOF after two lines
        nxt(); src1(1'b0, 1'b0, 1'b0, 8'h00); lpf = 16'd4; #1;
        chk("end1_busy", busy, 0);
        chk("end1_grant_id_hold", gid, 1);
        nxt(); #1;
        chk("g2_id", gid, 0);
        chk("g2_m_tdata", m_data, 8'h30);
        chk("g2_m_tlast", m_last, 1);
        nxt(); src0(1'b1, 1'b0, 1'b1, 8'h31); #1;
        chk("g2_l2_data", m_data, 8'h31);
        nxt(); src0(1'b1, 1'b1, 1'b0, 8'h40); #1;
        chk("abort_s0_tready", s0_ready, 0);
        chk("abort_m_tvalid", m_valid, 0);
        chk("abort_busy", busy, 1);
        nxt(); #1;
        chk("short_stb_on", short_stb, 1);
        chk("short_busy", busy, 0);
        chk("short_m_tvalid", m_valid, 0);
        nxt(); src0(1'b1, 1'b1, 1'b1, 8'h40); lpf = 16'd1; #1;
        chk("short_stb_off", short_stb, 0);
        chk("regrant_busy", busy, 1);
        chk("regrant_m_tdata", m_data, 8'h40);
        chk("regrant_m_tuser", m_user, 1);
        chk("regrant_m_tvalid", m_valid, 1);

        // Enable gating: SOF pending with i_enable=0
        nxt(); src0(1'b0, 1'b0, 1'b0, 8'h00); src1(1'b1, 1'b1, 1'b0, 8'h50); en = 1'b0; #1;
        chk("lpf1_end_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            nxt(); #1;
            chk("dis_busy", busy, 0);
            chk("dis_s1_tready", s1_ready, 0);
        end
        nxt(); en = 1'b1; #1;
        chk("en_same_cycle_busy", busy, 0);
        nxt(); #1;
        chk("en_busy", busy, 1);
        chk("en_id", gid, 1);
        chk("en_m_tdata", m_data, 8'h50);

        // Granted source stalls with tvalid=0
        nxt(); src1(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("stall_busy", busy, 1);
            chk("stall_timeout", tmo, 0);
            nxt();
        end
        #1;
`ifdef AXIS_FRAME_ARBITER_TIMEOUT_EN
        chk("tmo_busy", busy, 0);
        chk("tmo_flag", tmo, 1);
        src0(1'b1, 1'b1, 1'b0, 8'h60); src1(1'b1, 1'b1, 1'b0, 8'h70);
        nxt(); #1;
        chk("tmo_rr_id", gid, 0);
        chk("tmo_rr_data", m_data, 8'h60);
        chk("tmo_sticky", tmo, 1);
        clr = 1'b1;
        nxt(); clr = 1'b0; #1;
        chk("tmo_cleared", tmo, 0);
`else
        chk("no_tmo_busy", busy, 1);
        chk("no_tmo_flag", tmo, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_arbiter.md
Name: axis_frame_arbiter

Overview:
- Frame-granular arbiter sharing one AXI-Stream video sink (the fps_counter pass-through and its downstream) between two video sources.
- Grants the output to one source for a whole frame: from start-of-frame (tuser[0]) to the last tlast of that frame. Never switches sources mid-frame.
- Round-robin between sources.
- Configured and monitored by a register-map wrapper; no AXI-Lite of its own.

Parameters:
- AXIS_DATA_WIDTH, 8, tdata width of all streams.
- AXIS_DATA_USER_WIDTH, 1, tuser width; bit 0 is SOF.
- LINE_COUNT_WIDTH, 16, width of the lines-per-frame input and internal line counter.
- TIMEOUT_CYCLES, 1000000, stall limit for the optional watchdog.

Ports:
- i_axi_clk  in  1  clock.
- i_axi_rst  in  1  synchronous, active-low reset.
- i_enable  in  1  allow new grants.
- i_lines_per_frame  in  LINE_COUNT_WIDTH  tlast count per frame; 0 means end the frame only on the next SOF.
- i_clear  in  1  clear sticky status.
- i_s0_tuser/tvalid/tlast/tdata  in  USER/1/1/DATA  source 0 stream.
- o_s0_tready  out  1  source 0 ready.
- i_s1_tuser/tvalid/tlast/tdata  in  USER/1/1/DATA  source 1 stream.
- o_s1_tready  out  1  source 1 ready.
- o_m_tuser/tvalid/tlast/tdata  out  USER/1/1/DATA  shared output stream.
- i_m_tready  in  1  output ready.
- o_busy  out  1  a grant is active.
- o_grant_id  out  1  source currently or last granted.
- o_short_frame_stb  out  1  one-cycle pulse: SOF arrived before the line count completed.
- o_timeout  out  1  sticky watchdog flag (optional feature).

Behaviour:
- Reset (i_axi_rst=0 at a clock edge) forces:
  - state IDLE, line counter 0, last-grant pointer = 1 (so source 0 wins first);
  - o_busy=0, o_grant_id=0, o_short_frame_stb=0, o_timeout=0.
- While in reset, all treadys and o_m_tvalid are 0. Reset mid-frame simply abandons the frame; no flush.
- States: IDLE, GRANT.
- IDLE:
  - o_m_tvalid=0.
  - Source beats with tvalid=1 and tuser[0]=0 are accepted and dropped (tready=1). This aligns sources to frame start.
  - A source with tvalid=1 and tuser[0]=1 is a requester; its tready=0 (beat held).
  - If i_enable=1 and at least one requester exists: register grant on that edge and go to GRANT. A single requester wins; with two, the source not equal to the last-grant pointer wins.
  - Latency: SOF presented in cycle n is forwarded on o_m in cycle n+1.
- GRANT:
  - o_m_* is combinational from the granted source; granted tready = i_m_tready. Zero latency, no buffering.
  - Ungranted source: tready=0 (back-pressured, never dropped).
  - The line counter increments on each granted handshake with tlast=1.
  - When a tlast handshake makes count == i_lines_per_frame (nonzero): go to IDLE, counter to 0, pointer = grant id.
  - SOF on the granted source while in GRANT (not its first beat):
    - the beat is not forwarded (tready=0);
    - go to IDLE, counter to 0;
    - o_short_frame_stb=1 for one cycle, unless i_lines_per_frame==0;
    - the source is then a requester on the next cycle.
  - i_enable falling during GRANT has no effect until the frame ends.
  - i_lines_per_frame changing mid-frame takes effect immediately; if the count already exceeds it, the frame ends only by SOF.
  - Line counter saturates at all-ones.
- o_grant_id holds its value in IDLE.
- i_clear takes one cycle; it is overridden by a same-cycle set.

Optional Feature:
- Macro: AXIS_FRAME_ARBITER_TIMEOUT_EN.
- Defined:
  - In GRANT, a stall counter counts cycles with no granted handshake and resets on every handshake.
  - On reaching TIMEOUT_CYCLES: force IDLE, set o_timeout (sticky until i_clear), advance the pointer to the granted id.
- Not defined: no watchdog; o_timeout tied to 0; TIMEOUT_CYCLES unused.

Decomposition:
- Package axis_frame_arbiter_pkg holds:
  - state enumeration (IDLE=0, GRANT=1);
  - SOF bit index (0);
  - source-id width (1).
- One sub-module is natural: axis_rr_picker.
  - Combinational two-way round-robin.
  - Inputs: request vector, last pointer. Outputs: grant valid, grant id.

Test Plan:
- Both sources present SOF at the same cycle after reset, lines_per_frame=3 -> source 0 granted at n+1, three lines forwarded, then source 1 granted; o_grant_id 0 then 1.
- Source 0 starts mid-frame (2 non-SOF beats before SOF) -> both beats accepted and dropped, o_m_tvalid=0 until SOF forwarded.
- lines_per_frame=4, granted source sends SOF after 2 lines -> SOF not forwarded, o_short_frame_stb one cycle, o_busy falls, re-grant next cycle.
- i_m_tready held 0 for 50 cycles mid-frame -> granted beat stable on o_m, ungranted tready=0, no beat lost or duplicated.
- i_enable=0 with SOF pending -> no grant; i_enable=1 -> grant on next edge.
- Timeout macro, TIMEOUT_CYCLES=16, source stalls tvalid=0 -> o_timeout=1 after 16 cycles, IDLE, pointer advanced; i_clear -> o_timeout=0.
